// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, sequencer
// states, ALU function codes, instruction classes and the strobe bundle.
// Optional feature macro: ILLEGAL_TRAP_EN (consumed by control_sequencer).
package cpu_ctrl_pkg;

    // Opcode field values (ir[31:27])
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b01001;
    localparam logic [4:0] OPC_OR   = 5'b01010;
    localparam logic [4:0] OPC_ADDI = 5'b01011;
    localparam logic [4:0] OPC_ANDI = 5'b01100;
    localparam logic [4:0] OPC_ORI  = 5'b01101;
    localparam logic [4:0] OPC_NOP  = 5'b11001;
    localparam logic [4:0] OPC_HALT = 5'b11010;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    // Instruction classes; the sequencer only ever looks at these
    typedef enum logic [2:0] {
        CL_ALU_RR  = 3'd0,
        CL_ALU_IMM = 3'd1,
        CL_LDI     = 3'd2,
        CL_LD      = 3'd3,
        CL_ST      = 3'd4,
        CL_NOP     = 3'd5,
        CL_HALT    = 3'd6,
        CL_ILL     = 3'd7
    } iclass_t;

    // One bit per datapath/memory strobe
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic read;
        logic write;
    } ctrl_t;

    // Classes that compute base+offset addresses through Y/Z
    function automatic logic is_addr_class(input iclass_t c);
        return (c == CL_LDI) || (c == CL_LD) || (c == CL_ST);
    endfunction

    // Classes that continue into T6/T7 for a memory access
    function automatic logic is_mem_class(input iclass_t c);
        return (c == CL_LD) || (c == CL_ST);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: maps the IR opcode field to an instruction class and the
// ALU function used in the class's Z-load step.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output iclass_t          iclass,
    output logic [3:0]       alu_code
);

    // Pure lookup; anything not in the table is classified illegal
    always_comb begin
        iclass   = CL_ILL;
        alu_code = ALU_ADD;
        case (opcode)
            OPC_W'(OPC_LD):   iclass = CL_LD;
            OPC_W'(OPC_LDI):  iclass = CL_LDI;
            OPC_W'(OPC_ST):   iclass = CL_ST;
            OPC_W'(OPC_ADD):  begin iclass = CL_ALU_RR;  alu_code = ALU_ADD; end
            OPC_W'(OPC_SUB):  begin iclass = CL_ALU_RR;  alu_code = ALU_SUB; end
            OPC_W'(OPC_AND):  begin iclass = CL_ALU_RR;  alu_code = ALU_AND; end
            OPC_W'(OPC_OR):   begin iclass = CL_ALU_RR;  alu_code = ALU_OR;  end
            OPC_W'(OPC_ADDI): begin iclass = CL_ALU_IMM; alu_code = ALU_ADD; end
            OPC_W'(OPC_ANDI): begin iclass = CL_ALU_IMM; alu_code = ALU_AND; end
            OPC_W'(OPC_ORI):  begin iclass = CL_ALU_IMM; alu_code = ALU_OR;  end
            OPC_W'(OPC_NOP):  iclass = CL_NOP;
            OPC_W'(OPC_HALT): iclass = CL_HALT;
            default:          iclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath. Fetch runs T0..T2,
// execute runs T3..T7 depending on instruction class. Strobes decode
// combinationally from the registered state and the current opcode.
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined an unsupported
// opcode parks the machine in HALT with illegal held high until reset;
// otherwise illegal pulses in T3 and the opcode behaves as a nop.
//
// Memory handshake: Read/Write is a level request raised by the sequencer.
// mem_ready is a completion strobe from memory, valid only while a request
// is up (T1, T6 for ld, T7 for st). The request stays asserted up to and
// including the cycle where mem_ready=1; the sequencer advances on that edge.
// mem_ready is ignored in every other state.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int OPC_W    = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                Cout,
    output logic                Read,
    output logic                Write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                illegal,
    output logic [3:0]          dbg_state
);

    state_t     state;
    logic       t1_wait;    // set after the first T1 cycle so PCin pulses once
    logic       trap_flag;  // sticky illegal indication (trap build only)
    iclass_t    iclass;
    logic [3:0] alu_code;
    ctrl_t      ctl;
    logic [3:0] alu_sel;
    logic       unused_ir;

    assign unused_ir = ^ir[31-OPC_W:0];
    assign dbg_state = state;

    ctrl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode   (ir[31 -: OPC_W]),
        .iclass   (iclass),
        .alu_code (alu_code)
    );

    // Sequencer state register with memory-wait holds and halt parking
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RST;
            t1_wait   <= 1'b0;
            trap_flag <= 1'b0;
        end else begin
            t1_wait <= 1'b0;
            case (state)
                ST_RST: state <= ST_T0;
                ST_T0:  state <= ST_T1;
                ST_T1: begin
                    if (mem_ready) begin
                        state <= ST_T2;
                    end else begin
                        t1_wait <= 1'b1;
                    end
                end
                ST_T2:  state <= ST_T3;
                ST_T3: begin
                    case (iclass)
                        CL_NOP:  state <= ST_T0;
                        CL_HALT: state <= ST_HALT;
                        CL_ILL: begin
`ifdef ILLEGAL_TRAP_EN
                            state     <= ST_HALT;
                            trap_flag <= 1'b1;
`else
                            state     <= ST_T0;
`endif
                        end
                        default: state <= ST_T4;
                    endcase
                end
                ST_T4:  state <= ST_T5;
                ST_T5:  state <= is_mem_class(iclass) ? ST_T6 : ST_T0;
                ST_T6: begin
                    // ld waits for read data here; st only loads MDR
                    if (iclass != CL_LD || mem_ready) begin
                        state <= ST_T7;
                    end
                end
                ST_T7: begin
                    // st waits for write completion here; ld finishes at once
                    if (iclass != CL_ST || mem_ready) begin
                        state <= ST_T0;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    // Strobe decode from the current step and instruction class
    always_comb begin
        ctl     = '0;
        alu_sel = ALU_ADD;
        case (state)
            ST_T0: begin
                ctl.pc_out = 1'b1;
                ctl.mar_in = 1'b1;
                ctl.inc_pc = 1'b1;
                ctl.z_in   = 1'b1;
            end
            ST_T1: begin
                ctl.zlow_out = 1'b1;
                ctl.pc_in    = ~t1_wait;
                ctl.read     = 1'b1;
                ctl.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctl.mdr_out = 1'b1;
                ctl.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (iclass == CL_ALU_RR || iclass == CL_ALU_IMM) begin
                    ctl.grb   = 1'b1;
                    ctl.r_out = 1'b1;
                    ctl.y_in  = 1'b1;
                end else if (is_addr_class(iclass)) begin
                    ctl.grb    = 1'b1;
                    ctl.ba_out = 1'b1;
                    ctl.y_in   = 1'b1;
                end
            end
            ST_T4: begin
                if (iclass == CL_ALU_RR) begin
                    ctl.grc   = 1'b1;
                    ctl.r_out = 1'b1;
                    ctl.z_in  = 1'b1;
                    alu_sel   = alu_code;
                end else if (iclass == CL_ALU_IMM) begin
                    ctl.c_out = 1'b1;
                    ctl.z_in  = 1'b1;
                    alu_sel   = alu_code;
                end else if (is_addr_class(iclass)) begin
                    ctl.c_out = 1'b1;
                    ctl.z_in  = 1'b1;
                    alu_sel   = ALU_ADD;
                end
            end
            ST_T5: begin
                ctl.zlow_out = 1'b1;
                if (is_mem_class(iclass)) begin
                    ctl.mar_in = 1'b1;
                end else begin
                    ctl.gra  = 1'b1;
                    ctl.r_in = 1'b1;
                end
            end
            ST_T6: begin
                if (iclass == CL_LD) begin
                    ctl.read   = 1'b1;
                    ctl.mdr_in = 1'b1;
                end else if (iclass == CL_ST) begin
                    ctl.gra    = 1'b1;
                    ctl.r_out  = 1'b1;
                    ctl.mdr_in = 1'b1;
                end
            end
            ST_T7: begin
                if (iclass == CL_LD) begin
                    ctl.mdr_out = 1'b1;
                    ctl.gra     = 1'b1;
                    ctl.r_in    = 1'b1;
                end else if (iclass == CL_ST) begin
                    ctl.mdr_out = 1'b1;
                    ctl.write   = 1'b1;
                end
            end
            default: ctl = '0;
        endcase
    end

    assign PCout   = ctl.pc_out;
    assign PCin    = ctl.pc_in;
    assign IncPC   = ctl.inc_pc;
    assign MARin   = ctl.mar_in;
    assign MDRin   = ctl.mdr_in;
    assign MDRout  = ctl.mdr_out;
    assign IRin    = ctl.ir_in;
    assign Yin     = ctl.y_in;
    assign Zin     = ctl.z_in;
    assign Zlowout = ctl.zlow_out;
    assign Gra     = ctl.gra;
    assign Grb     = ctl.grb;
    assign Grc     = ctl.grc;
    assign Rin     = ctl.r_in;
    assign Rout    = ctl.r_out;
    assign BAout   = ctl.ba_out;
    assign Cout    = ctl.c_out;
    assign Read    = ctl.read;
    assign Write   = ctl.write;

    // ALU function is only meaningful while Z is loading
    assign alu_op  = ctl.z_in ? ALU_OP_W'(alu_sel) : '0;
    assign run     = (state != ST_RST) && (state != ST_HALT);
    assign illegal = ((state == ST_T3) && (iclass == CL_ILL)) | trap_flag;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a per-instruction reference model expands each
// opcode into its expected per-cycle strobe vectors, a driver supplies ir and
// mem_ready, and a compare process checks every cycle against the queue.
module tb_control_sequencer;

    localparam int W = 25;
    localparam int PCOUT = 0,  PCIN = 1,  INCPC = 2,  MARIN = 3,  MDRIN = 4;
    localparam int MDROUT = 5, IRIN = 6,  YIN = 7,    ZIN = 8,    ZLOW = 9;
    localparam int GRA = 10,   GRB = 11,  GRC = 12,   RIN = 13,   ROUT = 14;
    localparam int BAOUT = 15, COUT = 16, READ = 17,  WRITE = 18, RUN = 19;
    localparam int ILL = 20;

    localparam int K_RR = 0, K_IMM = 1, K_LDI = 2, K_LD = 3, K_ST = 4;
    localparam int K_NOP = 5, K_HALT = 6, K_ILL = 7;

    // clock/reset block
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    always #5 clock = ~clock;

    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Read, Write, run, illegal;
    logic [3:0] alu_op;
    logic [3:0] dbg_state;

    control_sequencer #(.ALU_OP_W(4), .OPC_W(5)) dut (
        .clock(clock), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .Cout(Cout), .Read(Read), .Write(Write),
        .alu_op(alu_op), .run(run), .illegal(illegal), .dbg_state(dbg_state)
    );

    logic [W-1:0] act;
    assign act = {alu_op, illegal, run, Write, Read, Cout, BAout, Rout, Rin,
                  Grc, Grb, Gra, Zlowout, Zin, Yin, IRin, MDRout, MDRin,
                  MARin, IncPC, PCin, PCout};

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc_cnt = 0;
    logic [W-1:0] cur_exp;
    string        cur_name;

    function automatic logic [W-1:0] b(input int i);
        return W'(1) << i;
    endfunction

    function automatic logic [W-1:0] op(input int a);
        return W'(a) << 21;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int kind(input logic [4:0] o);
        case (o)
            5'b00011, 5'b00100, 5'b01001, 5'b01010: return K_RR;
            5'b01011, 5'b01100, 5'b01101:           return K_IMM;
            5'b00001: return K_LDI;
            5'b00000: return K_LD;
            5'b00010: return K_ST;
            5'b11001: return K_NOP;
            5'b11010: return K_HALT;
            default:  return K_ILL;
        endcase
    endfunction

    // ADD=0 SUB=1 AND=2 OR=3
    function automatic int alu_of(input logic [4:0] o);
        case (o)
            5'b00100:           return 1;
            5'b01001, 5'b01100: return 2;
            5'b01010, 5'b01101: return 3;
            default:            return 0;
        endcase
    endfunction

    // compare process: one check per cycle that has an expectation
    always @(negedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            cur_exp  = exp_q.pop_front();
            cur_name = name_q.pop_front();
            checks++;
            if (act !== cur_exp) begin
                errors++;
                $display("FAIL %s t=%0t got=%h exp=%h", cur_name, $time, act, cur_exp);
            end
        end
    end

    task automatic check_int(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
        end
    endtask

    // driver: one clock cycle of stimulus plus its expected outputs
    task automatic cycle(input logic [31:0] irv, input logic [W-1:0] e,
                         input logic mr, input string nm);
        @(negedge clock);
        ir        = irv;
        mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        cyc_cnt++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset     = 1'b1;
            mem_ready = rbit();
            if (i > 0) begin
                exp_q.push_back('0);
                name_q.push_back("rst_hold");
            end
        end
        @(negedge clock);
        reset     = 1'b0;
        mem_ready = rbit();
        exp_q.push_back('0);
        name_q.push_back("rst_state");
    endtask

    // reference model: expand one instruction into its cycle sequence
    task automatic do_instr(input logic [4:0] opc, input int w1, input int w6,
                            input int w7, input int abort6, input int hold,
                            output int ncyc);
        logic [31:0] irv;
        int          k;
        bit          trap;
        irv     = {opc, 27'($urandom)};
        k       = kind(opc);
        cyc_cnt = 0;
        cycle(irv, b(RUN) | b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN), rbit(), "T0");
        for (int i = 0; i <= w1; i++)
            cycle(irv, b(RUN) | b(ZLOW) | b(READ) | b(MDRIN) | ((i == 0) ? b(PCIN) : W'(0)),
                  (i == w1), "T1");
        cycle(irv, b(RUN) | b(MDROUT) | b(IRIN), rbit(), "T2");
        case (k)
            K_RR, K_IMM, K_LDI: begin
                cycle(irv, b(RUN) | b(GRB) | b(YIN) | ((k == K_LDI) ? b(BAOUT) : b(ROUT)),
                      rbit(), "T3");
                cycle(irv, b(RUN) | b(ZIN) | ((k == K_RR) ? (b(GRC) | b(ROUT)) : b(COUT))
                      | op(alu_of(opc)), rbit(), "T4");
                cycle(irv, b(RUN) | b(ZLOW) | b(GRA) | b(RIN), rbit(), "T5");
            end
            K_LD, K_ST: begin
                cycle(irv, b(RUN) | b(GRB) | b(BAOUT) | b(YIN), rbit(), "T3");
                cycle(irv, b(RUN) | b(COUT) | b(ZIN) | op(0), rbit(), "T4");
                cycle(irv, b(RUN) | b(ZLOW) | b(MARIN), rbit(), "T5");
                if (k == K_LD) begin
                    for (int i = 0; i <= w6; i++) begin
                        if (i == abort6) begin
                            cycle(irv, b(RUN) | b(READ) | b(MDRIN), 1'b0, "T6");
                            ncyc = cyc_cnt;
                            return;
                        end
                        cycle(irv, b(RUN) | b(READ) | b(MDRIN), (i == w6), "T6");
                    end
                    cycle(irv, b(RUN) | b(MDROUT) | b(GRA) | b(RIN), rbit(), "T7");
                end else begin
                    cycle(irv, b(RUN) | b(GRA) | b(ROUT) | b(MDRIN), rbit(), "T6");
                    for (int i = 0; i <= w7; i++)
                        cycle(irv, b(RUN) | b(MDROUT) | b(WRITE), (i == w7), "T7");
                end
            end
            K_NOP, K_HALT: cycle(irv, b(RUN), rbit(), "T3");
            default:       cycle(irv, b(RUN) | b(ILL), rbit(), "T3");
        endcase
        ncyc = cyc_cnt;
`ifdef ILLEGAL_TRAP_EN
        trap = (k == K_HALT) || (k == K_ILL);
`else
        trap = (k == K_HALT);
`endif
        if (trap) begin
            for (int i = 0; i < hold; i++)
                cycle(irv, (k == K_ILL) ? b(ILL) : W'(0), rbit(), "HALT");
            do_reset(2);
        end
    endtask

    logic [4:0] legal_ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                   5'b00100, 5'b01001, 5'b01010, 5'b01011,
                                   5'b01100, 5'b01101, 5'b11001, 5'b11010};

    initial begin
        int n;
        logic [4:0] o;
        do_reset(2);

        // directed: latencies pin the model's step counts
        do_instr(5'b00011, 0, 0, 0, -1, 0, n); check_int("lat_add", n, 6);
        do_instr(5'b00000, 3, 2, 0, -1, 0, n); check_int("lat_ld_waits", n, 13);
        do_instr(5'b00010, 0, 0, 2, -1, 0, n); check_int("lat_st_waits", n, 10);
        do_instr(5'b00000, 0, 0, 0, -1, 0, n); check_int("lat_ld", n, 8);
        do_instr(5'b11001, 0, 0, 0, -1, 0, n); check_int("lat_nop", n, 4);
        do_instr(5'b01011, 0, 0, 0, -1, 0, n); check_int("lat_addi", n, 6);
        do_instr(5'b00001, 0, 0, 0, -1, 0, n); check_int("lat_ldi", n, 6);
        for (int i = 4; i < 10; i++) do_instr(legal_ops[i], 1, 0, 0, -1, 0, n);
        do_instr(5'b11111, 0, 0, 0, -1, 5, n); check_int("lat_illegal", n, 4);
        do_instr(5'b11010, 0, 0, 0, -1, 20, n); check_int("lat_halt", n, 4);

        // reset while waiting for read data in T6
        do_instr(5'b00000, 1, 3, 0, 1, 0, n);
        do_reset(2);

        // randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) o = 5'($urandom);
            else o = legal_ops[$urandom_range(0, 11)];
            do_instr(o, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), -1, $urandom_range(1, 4), n);
        end

        repeat (3) @(negedge clock);
        #2;
        check_int("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
